// File: rtl/power_cycle_ctrl.sv
// power_cycle_ctrl: microwave oven sequencing FSM.
// Handles start/stop/power buttons, the door interlock, power-level slot
// modulation of the magnetron and the end-of-cook beep.
// Build option: define POWER_CYCLE_CTRL_BEEP_EN to get an audible DONE phase
// lasting BEEP_CYCLES clocks; without it DONE lasts one cycle and beep is 0.
// No handshakes: all inputs are level samples, all outputs are levels except
// timer_clear, which is a registered one-cycle pulse.
module power_cycle_ctrl #(
  parameter int SLOT_CYCLES = 100,
  parameter int BEEP_CYCLES = 300
) (
  input  logic       clk,
  input  logic       clearn,
  input  logic       startn,
  input  logic       stopn,
  input  logic       door_closed,
  input  logic       power_keyn,
  input  logic [9:0] keypad,
  input  logic       timer_zero,
  output logic       timer_en,
  output logic       timer_clear,
  output logic       mag_on,
  output logic       beep,
  output logic [3:0] power_level,
  output logic [2:0] state
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_SET_PWR = 3'd1;
  localparam logic [2:0] S_COOK    = 3'd2;
  localparam logic [2:0] S_PAUSE   = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;

  localparam logic [9:0] CYC_LAST = 10'(SLOT_CYCLES - 1);

  // Reject illegal parameter values at elaboration time.
  if (SLOT_CYCLES < 2 || SLOT_CYCLES > 1023 || BEEP_CYCLES < 1 || BEEP_CYCLES > 1023) begin : g_bad_params
    $error("power_cycle_ctrl: SLOT_CYCLES or BEEP_CYCLES out of range");
  end

  logic [2:0] state_q, state_d;
  logic [3:0] level_q, level_d;
  logic [9:0] cyc_q, cyc_d;
  logic [3:0] slot_q, slot_d;
  logic       timer_clear_q, timer_clear_d;
  logic       start_prev_q, stop_prev_q, pwr_prev_q;

  logic       start_edge, stop_edge, pwr_edge;
  logic       zero_cnt;
  logic       key_one_hot;
  logic [3:0] key_level;
  logic       done_expired;

  // A press is the first cycle the button reads low after reading high.
  assign start_edge = start_prev_q & ~startn;
  assign stop_edge  = stop_prev_q  & ~stopn;
  assign pwr_edge   = pwr_prev_q   & ~power_keyn;

  // Keypad decode: exactly one key down selects a level, digit 0 means 10.
  always_comb begin
    key_one_hot = (keypad != 10'd0) && ((keypad & (keypad - 10'd1)) == 10'd0);
    key_level   = 4'd10;
    for (int i = 1; i < 10; i++) begin
      if (keypad[i]) key_level = 4'(i);
    end
  end

`ifdef POWER_CYCLE_CTRL_BEEP_EN
  logic [9:0] done_cnt_q, done_cnt_d;

  // DONE dwell counter: restarts every time DONE is entered.
  always_comb begin
    done_cnt_d = (state_q == S_DONE) ? done_cnt_q + 10'd1 : 10'd0;
  end

  // DONE dwell counter register.
  always_ff @(posedge clk or negedge clearn) begin
    if (!clearn) done_cnt_q <= 10'd0;
    else         done_cnt_q <= done_cnt_d;
  end

  assign done_expired = (done_cnt_q == 10'(BEEP_CYCLES - 1));
  assign beep         = (state_q == S_DONE);
`else
  assign done_expired = 1'b1;
  assign beep         = 1'b0;
`endif

  // Next state, power level and clear pulse; stop beats start beats power.
  // A start press in IDLE wins over a coincident power press even when the
  // door or timer keeps it from starting the cook.
  always_comb begin
    state_d       = state_q;
    level_d       = level_q;
    timer_clear_d = 1'b0;
    zero_cnt      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (stop_edge) begin
          timer_clear_d = 1'b1;
        end else if (start_edge) begin
          if (door_closed && !timer_zero) begin
            state_d  = S_COOK;
            zero_cnt = 1'b1;
          end
        end else if (pwr_edge) begin
          state_d = S_SET_PWR;
        end
      end
      S_SET_PWR: begin
        if (stop_edge) begin
          state_d = S_IDLE;
        end else if (key_one_hot) begin
          level_d = key_level;
          state_d = S_IDLE;
        end
      end
      S_COOK: begin
        if (stop_edge || !door_closed) state_d = S_PAUSE;
        else if (timer_zero)           state_d = S_DONE;
      end
      S_PAUSE: begin
        if (stop_edge) begin
          state_d       = S_IDLE;
          timer_clear_d = 1'b1;
        end else if (start_edge && door_closed) begin
          state_d = S_COOK;
        end
      end
      S_DONE: begin
        if (stop_edge || !door_closed || done_expired) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Slot modulation counters: advance only while cooking, zeroed on a fresh start.
  always_comb begin
    cyc_d  = cyc_q;
    slot_d = slot_q;
    if (zero_cnt) begin
      cyc_d  = 10'd0;
      slot_d = 4'd0;
    end else if (state_q == S_COOK) begin
      if (cyc_q == CYC_LAST) begin
        cyc_d  = 10'd0;
        slot_d = (slot_q == 4'd9) ? 4'd0 : slot_q + 4'd1;
      end else begin
        cyc_d = cyc_q + 10'd1;
      end
    end
  end

  // State, level, counters, clear pulse and button history registers.
  always_ff @(posedge clk or negedge clearn) begin
    if (!clearn) begin
      state_q       <= S_IDLE;
      level_q       <= 4'd10;
      cyc_q         <= 10'd0;
      slot_q        <= 4'd0;
      timer_clear_q <= 1'b0;
      start_prev_q  <= 1'b1;
      stop_prev_q   <= 1'b1;
      pwr_prev_q    <= 1'b1;
    end else begin
      state_q       <= state_d;
      level_q       <= level_d;
      cyc_q         <= cyc_d;
      slot_q        <= slot_d;
      timer_clear_q <= timer_clear_d;
      start_prev_q  <= startn;
      stop_prev_q   <= stopn;
      pwr_prev_q    <= power_keyn;
    end
  end

  // Door acts combinationally on the magnetron so opening it cuts power at once.
  assign mag_on      = (state_q == S_COOK) && (slot_q < level_q) && door_closed;
  assign timer_en    = (state_q == S_COOK);
  assign timer_clear = timer_clear_q;
  assign power_level = level_q;
  assign state       = state_q;

endmodule
